// File: rtl/wm_control_panel_if.sv
// Link between the front panel and the washing-machine cycle controller.
// The panel (master) drives the launch/freeze/option lines; the controller
// (slave) reports its idle status on done.
interface wm_control_panel_if;
    logic start;
    logic time_pause;
    logic double_wash;
    logic dry_wash;
    logic done;

    modport master (
        output start,
        output time_pause,
        output double_wash,
        output dry_wash,
        input  done
    );

    modport slave (
        input  start,
        input  time_pause,
        input  double_wash,
        input  dry_wash,
        output done
    );
endinterface

// File: rtl/wm_control_panel.sv
// Washing-machine front panel: synchronizes raw buttons/switches/door,
// debounces start and pause, launches the controller with latched options,
// tracks the running cycle via done, drives the door lock and fault pulses.
module wm_control_panel #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int LAUNCH_TIMEOUT  = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       btn_start_raw,
    input  logic                       btn_pause_raw,
    input  logic                       sw_double_raw,
    input  logic                       sw_dry_raw,
    input  logic                       door_closed_raw,
    wm_control_panel_if.master         ctrl,
    output logic                       door_lock,
    output logic                       err_door,
    output logic                       err_launch
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int LW = (LAUNCH_TIMEOUT > 1) ? $clog2(LAUNCH_TIMEOUT) : 1;

    // Bit positions inside the synchronized input vector
    localparam int B_START = 0;
    localparam int B_PAUSE = 1;
    localparam int B_DBL   = 2;
    localparam int B_DRY   = 3;
    localparam int B_DOOR  = 4;

    typedef enum logic [1:0] {
        PANEL_IDLE,
        PANEL_LAUNCH,
        PANEL_RUN,
        PANEL_PAUSE
    } panel_state_t;

    logic [4:0]   raw_vec;
    logic [4:0]   sync1_reg;
    logic [4:0]   sync2_reg;
    logic [1:0]   ev_vec;      // registered rising-edge events: [0] start, [1] pause

    panel_state_t state_reg, state_next;
    logic [LW-1:0] lcnt_reg, lcnt_next;
    logic         start_reg, start_next;
    logic         err_door_reg, err_door_next;
    logic         err_launch_reg, err_launch_next;
    logic         dbl_reg, dbl_next;
    logic         dry_reg, dry_next;

    assign raw_vec = {door_closed_raw, sw_dry_raw, sw_double_raw, btn_pause_raw, btn_start_raw};

    // Two-flop synchronizer for every raw asynchronous input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= raw_vec;
            sync2_reg <= sync1_reg;
        end
    end

    // Debounce plus registered rising-edge detect for the two buttons
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_btn
            logic [CW-1:0] cnt_reg;
            logic          db_reg;
            logic          db_dly_reg;
            logic          ev_reg;

            // db flips only after the synchronized level has disagreed for DEBOUNCE_CYCLES edges
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_reg    <= '0;
                    db_reg     <= 1'b0;
                    db_dly_reg <= 1'b0;
                    ev_reg     <= 1'b0;
                end else begin
                    db_dly_reg <= db_reg;
                    ev_reg     <= db_reg & ~db_dly_reg;
                    if (sync2_reg[gi] == db_reg) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg == CW'(DEBOUNCE_CYCLES - 1)) begin
                        db_reg  <= ~db_reg;
                        cnt_reg <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
            end

            assign ev_vec[gi] = ev_reg;
        end
    endgenerate

    // Panel state, launch counter, option latches and one-cycle pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= PANEL_IDLE;
            lcnt_reg       <= '0;
            start_reg      <= 1'b0;
            err_door_reg   <= 1'b0;
            err_launch_reg <= 1'b0;
            dbl_reg        <= 1'b0;
            dry_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            lcnt_reg       <= lcnt_next;
            start_reg      <= start_next;
            err_door_reg   <= err_door_next;
            err_launch_reg <= err_launch_next;
            dbl_reg        <= dbl_next;
            dry_reg        <= dry_next;
        end
    end

    // Next-state logic; done outranks pause, stray events are dropped
    always_comb begin
        state_next      = state_reg;
        lcnt_next       = lcnt_reg;
        start_next      = 1'b0;
        err_door_next   = 1'b0;
        err_launch_next = 1'b0;
        dbl_next        = dbl_reg;
        dry_next        = dry_reg;
        case (state_reg)
            PANEL_IDLE: begin
                if (ev_vec[B_START]) begin
                    if (sync2_reg[B_DOOR]) begin
                        start_next = 1'b1;
                        dbl_next   = sync2_reg[B_DBL];
                        dry_next   = sync2_reg[B_DRY];
                        lcnt_next  = '0;
                        state_next = PANEL_LAUNCH;
                    end else begin
                        err_door_next = 1'b1;
                    end
                end
            end
            PANEL_LAUNCH: begin
                if (!ctrl.done) begin
                    state_next = PANEL_RUN;
                end else if (lcnt_reg == LW'(LAUNCH_TIMEOUT - 1)) begin
                    err_launch_next = 1'b1;
                    state_next      = PANEL_IDLE;
                end else begin
                    lcnt_next = lcnt_reg + LW'(1);
                end
            end
            PANEL_RUN: begin
                if (ctrl.done) begin
                    state_next = PANEL_IDLE;
                end else if (ev_vec[B_PAUSE]) begin
                    state_next = PANEL_PAUSE;
                end
            end
            PANEL_PAUSE: begin
                if (ctrl.done) begin
                    state_next = PANEL_IDLE;
                end else if (ev_vec[B_PAUSE]) begin
                    state_next = PANEL_RUN;
                end
            end
            default: state_next = PANEL_IDLE;
        endcase
        // Options never outlive the cycle they were latched for
        if (state_next == PANEL_IDLE && state_reg != PANEL_IDLE) begin
            dbl_next = 1'b0;
            dry_next = 1'b0;
        end
    end

    assign door_lock        = (state_reg != PANEL_IDLE);
    // An open door during launch/run freezes the controller until it closes again
    assign ctrl.time_pause  = (state_reg == PANEL_PAUSE) ||
                              (((state_reg == PANEL_LAUNCH) || (state_reg == PANEL_RUN)) && !sync2_reg[B_DOOR]);
    assign ctrl.start       = start_reg;
    assign ctrl.double_wash = dbl_reg;
    assign ctrl.dry_wash    = dry_reg;
    assign err_door         = err_door_reg;
    assign err_launch       = err_launch_reg;

endmodule

// File: tb/tb_wm_control_panel.sv
// Scoreboarded bench for wm_control_panel: a behavioural panel model predicts
// pulses (queued with their cycle) and output levels; a monitor compares.
module tb_wm_control_panel;
    localparam int DEB = 4;
    localparam int LTO = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic btn_start_raw = 1'b0;
    logic btn_pause_raw = 1'b0;
    logic sw_double_raw = 1'b0;
    logic sw_dry_raw = 1'b0;
    logic door_closed_raw = 1'b0;
    logic door_lock, err_door, err_launch;

    wm_control_panel_if cif();

    always #5 clk = ~clk;

    wm_control_panel #(.DEBOUNCE_CYCLES(DEB), .LAUNCH_TIMEOUT(LTO)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .btn_start_raw   (btn_start_raw),
        .btn_pause_raw   (btn_pause_raw),
        .sw_double_raw   (sw_double_raw),
        .sw_dry_raw      (sw_dry_raw),
        .door_closed_raw (door_closed_raw),
        .ctrl            (cif),
        .door_lock       (door_lock),
        .err_door        (err_door),
        .err_launch      (err_launch)
    );

    int total = 0;
    int bad = 0;

    typedef struct {
        int kind;   // 1 start, 2 err_door, 3 err_launch
        int cyc;
    } pulse_t;
    pulse_t exp_q[$];

    // Reference model state
    int         edge_cnt = 0;
    logic [4:0] m_p1 = '0;          // raw seen one edge ago
    logic [4:0] m_p2 = '0;          // raw seen two edges ago (synchronized view)
    logic [1:0] m_db = '0;
    logic [1:0] m_pipe0 = '0;
    logic [1:0] m_pipe1 = '0;
    int         m_run[2] = '{0, 0};
    int         m_mode = 0;         // 0 idle, 1 launching, 2 running, 3 paused
    int         m_lcnt = 0;
    logic       m_dbl = 1'b0, m_dry = 1'b0;
    logic       exp_lock = 1'b0, exp_tp = 1'b0;

    task automatic chk(input string nm, input logic act, input logic want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s got=%b want=%b t=%0t", nm, act, want, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic void model_reset();
        m_p1 = '0; m_p2 = '0; m_db = '0; m_pipe0 = '0; m_pipe1 = '0;
        m_run[0] = 0; m_run[1] = 0; m_mode = 0; m_lcnt = 0;
        m_dbl = 1'b0; m_dry = 1'b0; exp_lock = 1'b0; exp_tp = 1'b0;
        exp_q.delete();
    endfunction

    function automatic void push(input int kind);
        pulse_t p;
        p.kind = kind;
        p.cyc  = edge_cnt;
        exp_q.push_back(p);
    endfunction

    // Behavioural model: a button press counts once its synchronized level has
    // disagreed with the accepted level for DEB consecutive edges, and is acted
    // on two edges later.
    initial begin
        logic [4:0] raw, s;
        logic [1:0] ev;
        int prev;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_reset();
            end else begin
                edge_cnt++;
                raw = {door_closed_raw, sw_dry_raw, sw_double_raw, btn_pause_raw, btn_start_raw};
                s = m_p2;
                for (int b = 0; b < 2; b++) begin
                    ev[b] = m_pipe1[b];
                    m_pipe1[b] = m_pipe0[b];
                    m_pipe0[b] = 1'b0;
                    if (s[b] != m_db[b]) begin
                        m_run[b]++;
                        if (m_run[b] == DEB) begin
                            m_db[b] = s[b];
                            m_run[b] = 0;
                            m_pipe0[b] = s[b];
                        end
                    end else begin
                        m_run[b] = 0;
                    end
                end
                prev = m_mode;
                if (m_mode == 0) begin
                    if (ev[0]) begin
                        if (s[4]) begin
                            push(1);
                            m_dbl = s[2]; m_dry = s[3]; m_lcnt = 0; m_mode = 1;
                        end else begin
                            push(2);
                        end
                    end
                end else if (m_mode == 1) begin
                    if (!cif.done) m_mode = 2;
                    else if (m_lcnt == LTO - 1) begin push(3); m_mode = 0; end
                    else m_lcnt++;
                end else begin
                    if (cif.done) m_mode = 0;
                    else if (ev[1]) m_mode = (m_mode == 2) ? 3 : 2;
                end
                if (m_mode == 0 && prev != 0) begin
                    m_dbl = 1'b0; m_dry = 1'b0;
                end
                m_p2 = m_p1;
                m_p1 = raw;
                exp_lock = (m_mode != 0);
                exp_tp   = (m_mode == 3) || ((m_mode == 1 || m_mode == 2) && !m_p2[4]);
            end
        end
    end

    // Monitor: level checks each cycle, pulses popped from the scoreboard
    initial begin
        pulse_t p;
        int kind_act, n_hi;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("door_lock", door_lock, exp_lock);
                chk("time_pause", cif.time_pause, exp_tp);
                chk("double_wash", cif.double_wash, m_dbl);
                chk("dry_wash", cif.dry_wash, m_dry);
                while (exp_q.size() > 0 && exp_q[0].cyc < edge_cnt) begin
                    p = exp_q.pop_front();
                    total++; bad++;
                    $display("FAIL missing_pulse got=none want=kind%0d@cyc%0d", p.kind, p.cyc);
                end
                n_hi = int'(cif.start) + int'(err_door) + int'(err_launch);
                if (n_hi > 0) begin
                    kind_act = cif.start ? 1 : (err_door ? 2 : 3);
                    total++;
                    if (exp_q.size() == 0 || exp_q[0].cyc != edge_cnt) begin
                        bad++;
                        $display("FAIL unexpected_pulse got=kind%0d@cyc%0d want=none", kind_act, edge_cnt);
                    end else begin
                        p = exp_q.pop_front();
                        if (p.kind != kind_act || n_hi != 1) begin
                            bad++;
                            $display("FAIL pulse_kind got=kind%0d(n=%0d) want=kind%0d cyc=%0d", kind_act, n_hi, p.kind, p.cyc);
                        end else begin
                            $display("txn pulse kind=%0d cyc=%0d", kind_act, edge_cnt);
                        end
                    end
                end
            end
        end
    end

    task automatic launch_run(input logic dbl, input logic dry);
        sw_double_raw = dbl; sw_dry_raw = dry; cif.done = 1'b1; cyc(3);
        btn_start_raw = 1'b1; cyc(9);
        cif.done = 1'b0; cyc(3);
        btn_start_raw = 1'b0; cyc(8);
    endtask

    task automatic press_pause();
        btn_pause_raw = 1'b1; cyc(10);
        btn_pause_raw = 1'b0; cyc(8);
    endtask

    initial begin
        int lat, cs, ce, hs, hp, hd;
        bit seen;
        cif.done = 1'b1;
        door_closed_raw = 1'b1;
        sw_double_raw = 1'b1;
        cyc(3);
        // Reset state
        chk("rst_start", cif.start, 1'b0);
        chk("rst_tp", cif.time_pause, 1'b0);
        chk("rst_dbl", cif.double_wash, 1'b0);
        chk("rst_dry", cif.dry_wash, 1'b0);
        chk("rst_lock", door_lock, 1'b0);
        chk("rst_err_door", err_door, 1'b0);
        chk("rst_err_launch", err_launch, 1'b0);
        rst_n = 1'b1;
        cyc(4);

        // Start latency, option latch, lock
        btn_start_raw = 1'b1;
        lat = -1;
        for (int i = 1; i <= 30 && lat < 0; i++) begin
            @(negedge clk);
            if (cif.start) lat = i - 1;
        end
        total++;
        if (lat != DEB + 3) begin
            bad++;
            $display("FAIL start_latency got=%0d want=%0d", lat, DEB + 3);
        end
        chk("dbl_at_start", cif.double_wash, 1'b1);
        @(negedge clk);
        chk("lock_after_start", door_lock, 1'b1);
        cif.done = 1'b0;
        cyc(11);
        btn_start_raw = 1'b0;
        cyc(8);

        // Pause, resume, then finish
        press_pause();
        chk("tp_paused", cif.time_pause, 1'b1);
        press_pause();
        chk("tp_resumed", cif.time_pause, 1'b0);
        cif.done = 1'b1;
        cyc(3);
        chk("idle_after_done", door_lock, 1'b0);

        // Glitch shorter than the debounce window
        btn_start_raw = 1'b1; cyc(DEB - 1);
        btn_start_raw = 1'b0; cyc(15);
        chk("glitch_no_launch", door_lock, 1'b0);

        // Launch timeout with done stuck high
        sw_dry_raw = 1'b1;
        btn_start_raw = 1'b1; cs = -1; ce = -1;
        for (int i = 0; i < 60 && ce < 0; i++) begin
            @(negedge clk);
            if (i == 10) btn_start_raw = 1'b0;
            if (cif.start) cs = i;
            if (err_launch) ce = i;
        end
        total++;
        if (cs < 0 || ce < 0 || ce - cs != LTO) begin
            bad++;
            $display("FAIL launch_timeout got=%0d want=%0d", ce - cs, LTO);
        end
        chk("timeout_lock", door_lock, 1'b0);
        chk("timeout_dbl", cif.double_wash, 1'b0);
        chk("timeout_dry", cif.dry_wash, 1'b0);
        cyc(8);

        // Door opened during run freezes, closing releases
        launch_run(1'b0, 1'b1);
        door_closed_raw = 1'b0;
        @(negedge clk);
        chk("tp_door_early", cif.time_pause, 1'b0);
        cyc(2);
        chk("tp_door_open", cif.time_pause, 1'b1);
        door_closed_raw = 1'b1;
        cyc(3);
        chk("tp_door_closed", cif.time_pause, 1'b0);
        cif.done = 1'b1;
        cyc(3);
        // Start with door open
        door_closed_raw = 1'b0; cyc(3);
        btn_start_raw = 1'b1; seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (err_door) seen = 1'b1;
        end
        btn_start_raw = 1'b0;
        chk("err_door_seen", seen, 1'b1);
        chk("err_door_no_lock", door_lock, 1'b0);
        door_closed_raw = 1'b1;
        cyc(8);

        // done and pause event on the same edge while paused
        launch_run(1'b1, 1'b1);
        press_pause();
        btn_pause_raw = 1'b1; cyc(7);
        cif.done = 1'b1; cyc(3);
        btn_pause_raw = 1'b0;
        chk("tie_lock", door_lock, 1'b0);
        chk("tie_tp", cif.time_pause, 1'b0);
        chk("tie_dbl", cif.double_wash, 1'b0);
        chk("tie_dry", cif.dry_wash, 1'b0);
        cyc(8);

        // Reset mid-run clears outputs immediately
        launch_run(1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_lock", door_lock, 1'b0);
        chk("midrst_dbl", cif.double_wash, 1'b0);
        chk("midrst_tp", cif.time_pause, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        cif.done = 1'b1;
        cyc(4);

        // Randomized phase
        hs = 0; hp = 0; hd = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (hs == 0) begin btn_start_raw = ($urandom_range(0, 3) == 0); hs = $urandom_range(1, 12); end else hs--;
            if (hp == 0) begin btn_pause_raw = ($urandom_range(0, 2) == 0); hp = $urandom_range(1, 12); end else hp--;
            if (hd == 0) begin door_closed_raw = ($urandom_range(0, 5) != 0); hd = $urandom_range(1, 15); end else hd--;
            if ($urandom_range(0, 15) == 0) sw_double_raw = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 15) == 0) sw_dry_raw = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 9) == 0) cif.done = ~cif.done;
        end
        btn_start_raw = 1'b0; btn_pause_raw = 1'b0; door_closed_raw = 1'b1; cif.done = 1'b1;
        cyc(30);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain got=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/wm_control_panel.md
Name: wm_control_panel

Overview:
Front-panel stage directly upstream of the washing-machine cycle controller. It synchronizes and debounces the raw start and pause buttons, and latches the double-wash and dry-wash option switches at launch. It drives the controller's start, time_pause, double_wash and dry_wash inputs. It watches the controller's done output to track the running cycle, and owns the door-lock and the fault pulses.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive cycles a synchronized button must differ from its debounced value before the debounced value flips (valid range 2..255).
LAUNCH_TIMEOUT, 8, cycles to wait for done to fall after a start pulse before declaring a launch fault (valid range 2..255).

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  asynchronous active-low reset
btn_start_raw  input  1  raw start button, asynchronous, bouncy
btn_pause_raw  input  1  raw pause/resume button, asynchronous, bouncy
sw_double_raw  input  1  raw double-wash switch, asynchronous
sw_dry_raw  input  1  raw dry-wash (steam) switch, asynchronous
door_closed_raw  input  1  door sensor, 1 = closed, asynchronous
done  input  1  controller done; high only while the controller is idle
start  output  1  one-cycle start pulse to the controller
time_pause  output  1  freeze request to the controller
double_wash  output  1  latched option to the controller
dry_wash  output  1  latched option to the controller
door_lock  output  1  door latch solenoid, 1 = locked
err_door  output  1  one-cycle pulse: start pressed with door open
err_launch  output  1  one-cycle pulse: controller did not leave idle

Behaviour:
- Reset (async assert, sync release): state PANEL_IDLE. All sync flops, debounced values, counters and outputs are 0.
- Synchronization: every raw input passes through a 2-flop synchronizer. Only synchronized values are used below.
- Debounce (start and pause buttons only):
  - A per-button counter increments on each cycle where sync != db.
  - The counter clears whenever sync == db.
  - When the counter is at DEBOUNCE_CYCLES-1 and sync != db at a clock edge, db toggles and the counter clears.
  - A pulse shorter than DEBOUNCE_CYCLES cycles never changes db.
  - Edge events: start_ev = db_start rising; pause_ev = db_pause rising. Falling edges are ignored.
- Latency: with a clean raw start and the door closed, start is high in exactly one cycle, DEBOUNCE_CYCLES+3 cycles after the first clock edge that samples the raw level (7 with defaults).
- FSM states: PANEL_IDLE, PANEL_LAUNCH, PANEL_RUN, PANEL_PAUSE.
  - PANEL_IDLE, start_ev with door closed: register start=1 for one cycle. In the same edge, latch double_wash and dry_wash from the synchronized switches. Go to PANEL_LAUNCH and clear the launch counter.
  - PANEL_IDLE, start_ev with door open: pulse err_door for one cycle and stay in PANEL_IDLE.
  - PANEL_LAUNCH, done==0: go to PANEL_RUN.
  - PANEL_LAUNCH, done==1: increment the launch counter. At LAUNCH_TIMEOUT-1, pulse err_launch, clear the options and go to PANEL_IDLE.
  - PANEL_RUN, done==1: go to PANEL_IDLE.
  - PANEL_RUN, pause_ev: go to PANEL_PAUSE.
  - PANEL_PAUSE, done==1: go to PANEL_IDLE.
  - PANEL_PAUSE, pause_ev: go to PANEL_RUN.
  - Every transition into PANEL_IDLE clears double_wash and dry_wash to 0 at that edge.
- Priority:
  - done==1 beats pause_ev in PANEL_RUN and PANEL_PAUSE.
  - start_ev outside PANEL_IDLE is ignored.
  - pause_ev in PANEL_IDLE or PANEL_LAUNCH is ignored; it is not queued.
- Outputs (combinational decode of registered state and synchronized door):
  - door_lock = 1 in PANEL_LAUNCH, PANEL_RUN and PANEL_PAUSE.
  - time_pause = (state == PANEL_PAUSE) OR (state in {PANEL_LAUNCH, PANEL_RUN} AND door_sync == 0). An open door during a cycle always freezes the controller. time_pause drops when the door closes again, with no button press needed.
  - start, err_door and err_launch are registered and high for exactly one cycle.
- Option switches are not debounced. Changes after launch have no effect until the next launch.
- Reset mid-operation: all outputs return to 0 asynchronously (the door unlocks). The debounced state is lost. A button held through reset release produces a new start_ev after the debounce period.

Test Plan:
- Reset, then raw start held high for 20 cycles, door closed, sw_double=1 -> start high for exactly 1 cycle at cycle 7. double_wash=1 from that cycle. door_lock=1 from the next cycle.
- Raw start glitch of 3 cycles (DEBOUNCE_CYCLES=4) -> no start and no state change; counter back to 0.
- Launch, then done falls 2 cycles after start; debounced pause press; then a second press -> time_pause 1 then 0. State goes RUN, PAUSE, RUN.
- Launch with done held at 1 -> err_launch pulse 8 cycles after entering LAUNCH. door_lock=0 and options=0 afterward.
- door_closed_raw=0 during RUN -> time_pause=1 three cycles later. Door closed again -> time_pause=0 three cycles later. Start pressed with door open in IDLE -> err_door pulse, no start.
- In PAUSE, done rises in the same cycle as pause_ev -> state goes to IDLE. time_pause=0, door_lock=0, double_wash/dry_wash=0. rst_n pulsed low mid-RUN -> all outputs 0 immediately.
